// File: rtl/range_tracker_if.sv
// range_tracker_if: sample/control/result bundle for range_tracker.
//   data_in  sample bus (master -> slave)
//   go       start measurement (master -> slave)
//   finish   end measurement, finish-cycle sample included (master -> slave)
//   sel      result select 00 range, 01 min, 10 max, 11 count (master -> slave)
//   result   selected published value (slave -> master)
//   done     one-cycle pulse when results publish (slave -> master)
//   busy     high while a run is active (slave -> master)
//   error    high while in the error state (slave -> master)
interface range_tracker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             go;
    logic             finish;
    logic [1:0]       sel;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             error;

    modport master (
        output data_in, go, finish, sel,
        input  result, done, busy, error
    );

    modport slave (
        input  data_in, go, finish, sel,
        output result, done, busy, error
    );
endinterface

// File: rtl/range_tracker.sv
// range_tracker: tracks min/max/count of a sample stream between go and finish.
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset
//   bus    range_tracker_if slave: data_in/go/finish/sel in, result/done/busy/error out
module range_tracker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    range_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur_min, cur_max, pub_min, pub_max, pub_rng;
    logic [CNT_W-1:0] cur_cnt, pub_cnt;
    logic             done_q, busy_q, error_q;
    logic             lt_min, gt_max;
    logic [WIDTH-1:0] fold_min, fold_max;
    logic [CNT_W-1:0] fold_cnt;

    assign lt_min   = SIGNED ? ($signed(bus.data_in) < $signed(cur_min)) : (bus.data_in < cur_min);
    assign gt_max   = SIGNED ? ($signed(bus.data_in) > $signed(cur_max)) : (bus.data_in > cur_max);
    assign fold_min = lt_min ? bus.data_in : cur_min;
    assign fold_max = gt_max ? bus.data_in : cur_max;
    // count saturates at all-ones instead of wrapping
    assign fold_cnt = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_min <= '0;
            cur_max <= '0;
            cur_cnt <= '0;
            pub_min <= '0;
            pub_max <= '0;
            pub_rng <= '0;
            pub_cnt <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (bus.go) begin
                        state   <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        cur_min <= fold_min;
                        cur_max <= fold_max;
                        cur_cnt <= fold_cnt;
                        if (bus.finish) begin
                            pub_min <= fold_min;
                            pub_max <= fold_max;
                            pub_cnt <= fold_cnt;
                            // modulo-2^WIDTH difference is the exact unsigned span in both modes
                            pub_rng <= fold_max - fold_min;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    if (bus.go && !bus.finish) begin
                        state   <= ACTIVE;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        cur_min <= bus.data_in;
                        cur_max <= bus.data_in;
                        cur_cnt <= CNT_W'(1);
                    end else if (bus.finish) begin
                        state   <= ERROR;
                        error_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.result = (bus.sel == 2'd0) ? pub_rng :
                        (bus.sel == 2'd1) ? pub_min :
                        (bus.sel == 2'd2) ? pub_max : WIDTH'(pub_cnt);
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_range_tracker.sv
// tb_range_tracker: scoreboard bench for range_tracker (unsigned, signed and narrow-count instances).
module tb_range_tracker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] q0[$], q1[$], q2[$];

    always #10 clk = ~clk;

    range_tracker_if #(.WIDTH(8)) b0 ();
    range_tracker_if #(.WIDTH(8)) b1 ();
    range_tracker_if #(.WIDTH(8)) b2 ();

    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    range_tracker #(.WIDTH(8), .CNT_W(3), .SIGNED(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // monitors: every done pulse must match the next queued expectation
    always @(posedge clk) begin
        #1;
        if (b0.done) begin
            chk("u0_done_vs_error", {7'd0, b0.error}, 8'd0);
            if (q0.size() == 0) chk("u0_unexpected_done", {7'd0, b0.done}, 8'd0);
            else chk("u0_publish", b0.result, q0.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (b1.done) begin
            if (q1.size() == 0) chk("u1_unexpected_done", {7'd0, b1.done}, 8'd0);
            else chk("u1_publish", b1.result, q1.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (b2.done) begin
            if (q2.size() == 0) chk("u2_unexpected_done", {7'd0, b2.done}, 8'd0);
            else chk("u2_publish", b2.result, q2.pop_front());
        end
    end

    task automatic step(input int id, input logic g, input logic f, input logic [7:0] d);
        @(negedge clk);
        case (id)
            0: begin b0.go = g; b0.finish = f; b0.data_in = d; end
            1: begin b1.go = g; b1.finish = f; b1.data_in = d; end
            default: begin b2.go = g; b2.finish = f; b2.data_in = d; end
        endcase
        @(posedge clk);
        #1;
        b0.go = 1'b0; b0.finish = 1'b0;
        b1.go = 1'b0; b1.finish = 1'b0;
        b2.go = 1'b0; b2.finish = 1'b0;
    endtask

    task automatic rd(input int id, input logic [1:0] s, input logic [7:0] e, input string n);
        #1;
        case (id)
            0: b0.sel = s;
            1: b1.sel = s;
            default: b2.sel = s;
        endcase
        #1;
        chk(n, (id == 0) ? b0.result : (id == 1) ? b1.result : b2.result, e);
    endtask

    initial begin
        b0.go = 0; b0.finish = 0; b0.data_in = 0; b0.sel = 0;
        b1.go = 0; b1.finish = 0; b1.data_in = 0; b1.sel = 0;
        b2.go = 0; b2.finish = 0; b2.data_in = 0; b2.sel = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {7'd0, b0.busy}, 8'd0);
        chk("rst_error", {7'd0, b0.error}, 8'd0);
        chk("rst_done", {7'd0, b0.done}, 8'd0);
        rd(0, 2'd0, 8'h00, "rst_rng");
        rd(0, 2'd1, 8'h00, "rst_min");
        rd(0, 2'd2, 8'h00, "rst_max");
        rd(0, 2'd3, 8'h00, "rst_cnt");
        @(negedge clk);
        rst_n = 1'b1;

        // unsigned basic run
        rd(0, 2'd0, 8'h00, "t1_pre");
        q0.push_back(8'hE0);
        step(0, 1, 0, 8'h40);
        chk("t1_busy", {7'd0, b0.busy}, 8'd1);
        step(0, 0, 0, 8'h10);
        step(0, 0, 0, 8'hF0);
        step(0, 0, 1, 8'h80);
        chk("t1_busy_after", {7'd0, b0.busy}, 8'd0);
        rd(0, 2'd1, 8'h10, "t1_min");
        rd(0, 2'd2, 8'hF0, "t1_max");
        rd(0, 2'd3, 8'h04, "t1_cnt");

        // finish in IDLE -> ERROR, results held, then recovery
        step(0, 0, 1, 8'h00);
        chk("t3_error", {7'd0, b0.error}, 8'd1);
        chk("t3_busy", {7'd0, b0.busy}, 8'd0);
        rd(0, 2'd3, 8'h04, "t3_hold_cnt");
        rd(0, 2'd1, 8'h10, "t3_hold_min");
        rd(0, 2'd0, 8'hE0, "t3_hold_rng");
        q0.push_back(8'h00);
        step(0, 1, 0, 8'h05);
        chk("t3_error_clear", {7'd0, b0.error}, 8'd0);
        chk("t3_busy_again", {7'd0, b0.busy}, 8'd1);
        step(0, 0, 1, 8'h05);
        rd(0, 2'd3, 8'h02, "t3_cnt");
        rd(0, 2'd1, 8'h05, "t3_min");

        // go&finish mid-run -> ERROR, no done, results retained
        step(0, 1, 0, 8'h20);
        step(0, 1, 1, 8'h20);
        chk("t4_error", {7'd0, b0.error}, 8'd1);
        chk("t4_busy", {7'd0, b0.busy}, 8'd0);
        step(0, 0, 0, 8'h00);
        rd(0, 2'd0, 8'h00, "t4_rng");
        rd(0, 2'd3, 8'h02, "t4_cnt");
        rd(0, 2'd2, 8'h05, "t4_max");

        // signed extremes
        rd(1, 2'd0, 8'h00, "t2_pre");
        q1.push_back(8'hFF);
        step(1, 1, 0, 8'h7F);
        step(1, 0, 1, 8'h80);
        rd(1, 2'd1, 8'h80, "t2_min");
        rd(1, 2'd2, 8'h7F, "t2_max");
        rd(1, 2'd3, 8'h02, "t2_cnt");

        // 3-bit count saturation over 12 samples
        rd(2, 2'd3, 8'h00, "t5_pre");
        q2.push_back(8'h07);
        step(2, 1, 0, 8'h10);
        for (int i = 1; i <= 10; i++) step(2, 0, 0, 8'h10 + 8'(i));
        step(2, 0, 1, 8'h1B);
        rd(2, 2'd0, 8'h0B, "t5_rng");
        rd(2, 2'd1, 8'h10, "t5_min");
        rd(2, 2'd2, 8'h1B, "t5_max");

        // reset mid-run
        step(0, 1, 0, 8'h33);
        step(0, 0, 0, 8'h44);
        chk("t6_busy_pre", {7'd0, b0.busy}, 8'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_busy", {7'd0, b0.busy}, 8'd0);
        rd(0, 2'd0, 8'h00, "t6_rng");
        rd(0, 2'd1, 8'h00, "t6_min");
        rd(0, 2'd2, 8'h00, "t6_max");
        rd(0, 2'd3, 8'h00, "t6_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("q0_drained", 8'(q0.size()), 8'd0);
        chk("q1_drained", 8'(q1.size()), 8'd0);
        chk("q2_drained", 8'(q2.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
